// File: rtl/rv_pkg.sv
// Shared limits and helpers for the ready/valid register pipe.
// Occupancy width is derived here so the port and the counter agree.
package rv_pkg;

  localparam int RV_MAX_DEPTH = 16;
  localparam int RV_MAX_WIDTH = 64;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rv_stage.sv
// One pipe stage: valid bit plus payload register, zero extra latency.
// Loads when downstream is ready; holds otherwise. Flush clears the valid bit only.
module rv_stage
  import rv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (load) begin
      v <= in_v;
    end
  end

  // Payload only moves with a valid word, so bubbles do not toggle the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
    end else if (load && in_v && !flush) begin
      d <= in_d;
    end
  end

endmodule

// File: rtl/rv_pipe.sv
// DEPTH-stage valid/ready register pipe, DEPTH cycles latency, full throughput, combinational ready chain.
// Optional occupancy output built when RV_PIPE_OCC_EN is defined.
module rv_pipe
  import rv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef RV_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  generate
    if (WIDTH < 1 || WIDTH > RV_MAX_WIDTH || DEPTH < 1 || DEPTH > RV_MAX_DEPTH) begin : g_bad_param
      $error("rv_pipe: WIDTH must be 1..%0d and DEPTH 1..%0d", RV_MAX_WIDTH, RV_MAX_DEPTH);
    end
  endgenerate

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] stg_in_v;
  logic [WIDTH-1:0] stg_in_d [DEPTH];

  // A stage can take a word if it is empty or everything after it moves.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = ~v[i] | acc;
      rdy[i] = acc;
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign stg_in_v[i] = in_valid;
        assign stg_in_d[i] = in_data;
      end else begin : g_body
        assign stg_in_v[i] = v[i-1];
        assign stg_in_d[i] = d[i-1];
      end

      rv_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .load (rdy[i]),
        .in_v (stg_in_v[i]),
        .in_d (stg_in_d[i]),
        .v    (v[i]),
        .d    (d[i])
      );
    end
  endgenerate

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef RV_PIPE_OCC_EN
  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ <= occ + 1'b1;
    end else if (out_xfer && !in_xfer) begin
      occ <= occ - 1'b1;
    end
  end
`endif

endmodule
